// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: result payload, exception record,
// default requester count and the modulo helper used by the round-robin search.
package wb_port_arbiter_pkg;

   localparam int XLEN          = 64;
   localparam int TRANS_ID_BITS = 3;
   localparam int WB_ARB_NR_REQ = 3;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [XLEN-1:0]          data;
      exception_t               ex;
   } wb_req_t;

   // Single-step wrap: callers never pass idx >= 2*n.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back bundle: NR_REQ requester lanes on one side, one scoreboard lane on the other.
interface wb_port_arbiter_if
   import wb_port_arbiter_pkg::*;
#(
   parameter int NR_REQ = WB_ARB_NR_REQ
);

   logic [NR_REQ-1:0]                    req_valid_i;
   logic [NR_REQ-1:0]                    req_ready_o;
   logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] req_trans_id_i;
   logic [NR_REQ-1:0][XLEN-1:0]          req_data_i;
   exception_t [NR_REQ-1:0]              req_ex_i;

   logic                                 wb_valid_o;
   logic [TRANS_ID_BITS-1:0]             wb_trans_id_o;
   logic [XLEN-1:0]                      wb_data_o;
   exception_t                           wb_ex_o;

   modport slave (
      input  req_valid_i, req_trans_id_i, req_data_i, req_ex_i,
      output req_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o
   );

   modport master (
      output req_valid_i, req_trans_id_i, req_data_i, req_ex_i,
      input  req_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o
   );

endinterface

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first candidate at or after
// ptr (modulo NR_REQ), plus the pointer value that follows that grant.
module wb_rr_pick
   import wb_port_arbiter_pkg::*;
#(
   parameter  int NR_REQ = WB_ARB_NR_REQ,
   localparam int PTR_W  = $clog2(NR_REQ)
) (
   input  logic [NR_REQ-1:0] cand,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NR_REQ-1:0] grant,
   output logic [PTR_W-1:0]  ptr_nxt,
   output logic              any
);

   int idx;

   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      any     = 1'b0;
      idx     = 0;
      for (int k = 0; k < NR_REQ; k++) begin
         idx = rr_wrap(int'(ptr) + k, NR_REQ);
         if (!any && cand[idx]) begin
            grant[idx] = 1'b1;
            ptr_nxt    = PTR_W'(rr_wrap(idx + 1, NR_REQ));
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one registered scoreboard write-back lane between NR_REQ units.
// Define WB_ARB_SKID_EN to add a 1-entry skid buffer per requester (arbitration then runs on the buffers).
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NR_REQ = WB_ARB_NR_REQ
) (
   input logic              clk_i,
   input logic              rst_i,
   input logic              flush_i,
   wb_port_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NR_REQ);

   wb_req_t           in_req [NR_REQ];
   wb_req_t           src    [NR_REQ];
   wb_req_t           sel;
   logic [NR_REQ-1:0] cand;
   logic [NR_REQ-1:0] grant;
   logic [NR_REQ-1:0] ready;
   logic [PTR_W-1:0]  rr_q;
   logic [PTR_W-1:0]  rr_nxt;
   logic              any;
   logic              out_vld_p1;
   wb_req_t           out_req_p1;

   always_comb begin
      for (int i = 0; i < NR_REQ; i++) begin
         in_req[i].trans_id = bus.req_trans_id_i[i];
         in_req[i].data     = bus.req_data_i[i];
         in_req[i].ex       = bus.req_ex_i[i];
      end
   end

   wb_rr_pick #(.NR_REQ(NR_REQ)) u_pick (
      .cand    (cand),
      .ptr     (rr_q),
      .grant   (grant),
      .ptr_nxt (rr_nxt),
      .any     (any)
   );

`ifdef WB_ARB_SKID_EN
   logic [NR_REQ-1:0] skid_vld_p0;
   wb_req_t           skid_req_p0 [NR_REQ];

   assign cand = skid_vld_p0;
   assign src  = skid_req_p0;
   // A granted entry frees its slot this cycle, so the unit can refill it back-to-back.
   assign ready = (rst_i || flush_i) ? '0 : (~skid_vld_p0 | grant);

   // Stage p0: skid capture
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         skid_vld_p0 <= '0;
      end else begin
         for (int i = 0; i < NR_REQ; i++) begin
            if (flush_i)                              skid_vld_p0[i] <= 1'b0;
            else if (bus.req_valid_i[i] && ready[i]) skid_vld_p0[i] <= 1'b1;
            else if (grant[i])                       skid_vld_p0[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_REQ; i++) begin
         if (bus.req_valid_i[i] && ready[i]) skid_req_p0[i] <= in_req[i];
      end
   end
`else
   assign cand  = bus.req_valid_i;
   assign src   = in_req;
   assign ready = (rst_i || flush_i) ? '0 : grant;
`endif

   assign bus.req_ready_o = ready;

   always_comb begin
      sel = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         if (grant[i]) sel = src[i];
      end
   end

   // Stage p1: output register, loaded every cycle; flush squashes the grant and freezes rr_q
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_vld_p1 <= 1'b0;
         out_req_p1 <= '0;
         rr_q       <= '0;
      end else begin
         out_vld_p1 <= any && !flush_i;
         out_req_p1 <= sel;
         if (any && !flush_i) rr_q <= rr_nxt;
      end
   end

   assign bus.wb_valid_o    = out_vld_p1;
   assign bus.wb_trans_id_o = out_req_p1.trans_id;
   assign bus.wb_data_o     = out_req_p1.data;
   assign bus.wb_ex_o       = out_req_p1.ex;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the round-robin write-back port.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int N = 3;
`ifdef WB_ARB_SKID_EN
   localparam int LAT  = 2;
   localparam bit SKID = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit SKID = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.NR_REQ(N)) bus ();

   wb_port_arbiter #(.NR_REQ(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] vin = '0;
   wb_req_t      cur [N];

   int           m_rr;
   logic         m_ov;
   wb_req_t      m_out;
   logic         m_skv  [N];
   wb_req_t      m_skid [N];

   logic [N-1:0] e_rdy;
   logic         e_ov;
   wb_req_t      e_out;
   logic [N-1:0] s_rdy;
   logic         s_wv;
   wb_req_t      s_out;

   function automatic wb_req_t rnd_req();
      wb_req_t r;
      r.trans_id = TRANS_ID_BITS'($urandom);
      r.data     = {$urandom, $urandom};
      r.ex.cause = {$urandom, $urandom};
      r.ex.tval  = {$urandom, $urandom};
      r.ex.valid = 1'($urandom);
      return r;
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.req_valid_i[i]    = vin[i];
         bus.req_trans_id_i[i] = cur[i].trans_id;
         bus.req_data_i[i]     = cur[i].data;
         bus.req_ex_i[i]       = cur[i].ex;
      end
   endtask

   task automatic m_reset();
      m_rr  = 0;
      m_ov  = 1'b0;
      m_out = '0;
      for (int i = 0; i < N; i++) m_skv[i] = 1'b0;
   endtask

   // One clock: sample DUT at negedge, record model expectations, advance model, step past posedge.
   task automatic cycle();
      int g;
      @(negedge clk);
      s_rdy          = bus.req_ready_o;
      s_wv           = bus.wb_valid_o;
      s_out.trans_id = bus.wb_trans_id_o;
      s_out.data     = bus.wb_data_o;
      s_out.ex       = bus.wb_ex_o;
      e_ov  = m_ov;
      e_out = m_out;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (g < 0 && (SKID ? m_skv[i] : vin[i])) g = i;
      end
      for (int i = 0; i < N; i++)
         e_rdy[i] = !flush && (SKID ? (!m_skv[i] || i == g) : (i == g));
      m_ov  = (g >= 0) && !flush;
      m_out = (g >= 0) ? (SKID ? m_skid[g] : cur[g]) : '0;
      if (g >= 0 && !flush) m_rr = (g + 1) % N;
      for (int i = 0; i < N; i++) begin
         if (flush) m_skv[i] = 1'b0;
         else if (vin[i] && e_rdy[i]) begin
            m_skv[i]  = 1'b1;
            m_skid[i] = cur[i];
         end else if (i == g) m_skv[i] = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      flush = 1'b0;
      vin   = '0;
      apply();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) cur[i] = rnd_req();
      vin = '1;
      apply();
      @(negedge clk);
      n_checks++;
      if (bus.req_ready_o !== '0) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready_o);
      end
      n_checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.wb_valid_o);
      end
      n_checks++;
      if (bus.wb_trans_id_o !== '0) begin
         n_fail++; $display("FAIL reset_trans_id: got %0d expected 0", bus.wb_trans_id_o);
      end
      n_checks++;
      if (bus.wb_data_o !== '0) begin
         n_fail++; $display("FAIL reset_data: got %0h expected 0", bus.wb_data_o);
      end
      n_checks++;
      if (bus.wb_ex_o !== '0) begin
         n_fail++; $display("FAIL reset_ex: got %0h expected 0", bus.wb_ex_o);
      end
      n_checks++;
      if (dut.rr_q !== '0) begin
         n_fail++; $display("FAIL reset_rr: got %0d expected 0", dut.rr_q);
      end
      @(posedge clk);
      #1;
      vin = '0;
      apply();
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) begin
         cur[i] = rnd_req();
         cur[i].trans_id = TRANS_ID_BITS'(i + 1);
      end
      vin = '1;
      apply();
      for (int c = 0; c < LAT + 6; c++) begin
         cycle();
         if (c == 0) begin
            n_checks++;
            if (s_rdy !== (SKID ? 3'b111 : 3'b001)) begin
               n_fail++; $display("FAIL rr_first_ready: got %b expected %b", s_rdy, SKID ? 3'b111 : 3'b001);
            end
         end
         if (c >= LAT) begin
            int exp_tag;
            exp_tag = ((c - LAT) % N) + 1;
            n_checks++;
            if (s_wv !== 1'b1 || s_out.trans_id !== TRANS_ID_BITS'(exp_tag)) begin
               n_fail++;
               $display("FAIL rr_sequence[%0d]: got valid=%b tag=%0d expected valid=1 tag=%0d", c, s_wv, s_out.trans_id, exp_tag);
            end
         end
      end
      vin = '0;
      apply();
      repeat (6) cycle();
   endtask

   task automatic test_single();
      cur[2] = rnd_req();
      cur[2].trans_id = TRANS_ID_BITS'(5);
      cur[2].data     = 64'hDEAD;
      vin = 3'b100;
      apply();
      cycle();
      n_checks++;
      if (s_rdy !== (SKID ? 3'b111 : 3'b100)) begin
         n_fail++; $display("FAIL single_ready: got %b expected %b", s_rdy, SKID ? 3'b111 : 3'b100);
      end
      vin = '0;
      apply();
      for (int c = 1; c <= LAT; c++) begin
         cycle();
         n_checks++;
         if (c < LAT) begin
            if (s_wv !== 1'b0) begin
               n_fail++; $display("FAIL single_early: got valid=%b expected 0", s_wv);
            end
         end else if (s_wv !== 1'b1 || s_out.trans_id !== TRANS_ID_BITS'(5) || s_out.data !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL single_out: got valid=%b tag=%0d data=%0h expected valid=1 tag=5 data=dead", s_wv, s_out.trans_id, s_out.data);
         end
      end
      repeat (3) cycle();
   endtask

   task automatic test_traffic();
      int unsigned p [N];
      int bound;
      int ncyc;
      int wait_c [N];
      for (int ph = 0; ph < 3; ph++) begin
         case (ph)
            0: begin p = '{100, 100, 0}; bound = 2; ncyc = 24; end
            1: begin
               for (int i = 0; i < N; i++) p[i] = $urandom_range(90, 30);
               bound = N; ncyc = 300;
            end
            default: begin p = '{100, 100, 100}; bound = N; ncyc = 60; end
         endcase
         for (int i = 0; i < N; i++) wait_c[i] = 0;
         for (int c = 0; c < ncyc; c++) begin
            cycle();
            n_checks++;
            if (s_rdy !== e_rdy) begin
               n_fail++; $display("FAIL traffic_ready ph%0d c%0d: got %b expected %b", ph, c, s_rdy, e_rdy);
            end
            n_checks++;
            if (s_wv !== e_ov) begin
               n_fail++; $display("FAIL traffic_valid ph%0d c%0d: got %b expected %b", ph, c, s_wv, e_ov);
            end
            if (e_ov) begin
               n_checks++;
               if (s_out !== e_out) begin
                  n_fail++;
                  $display("FAIL traffic_payload ph%0d c%0d: got tag=%0d data=%0h ex=%b expected tag=%0d data=%0h ex=%b",
                           ph, c, s_out.trans_id, s_out.data, s_out.ex.valid, e_out.trans_id, e_out.data, e_out.ex.valid);
               end
            end
            for (int i = 0; i < N; i++) begin
               if (vin[i]) begin
                  wait_c[i] = s_rdy[i] ? 0 : wait_c[i] + 1;
                  n_checks++;
                  if (wait_c[i] >= bound) begin
                     n_fail++; $display("FAIL starvation req%0d ph%0d: waited %0d cycles, limit %0d", i, ph, wait_c[i], bound - 1);
                  end
               end else wait_c[i] = 0;
            end
            for (int i = 0; i < N; i++) begin
               if (vin[i] && e_rdy[i]) begin
                  cur[i] = rnd_req();
                  vin[i] = ($urandom_range(99) < p[i]);
               end else if (!vin[i] && ($urandom_range(99) < p[i])) begin
                  cur[i] = rnd_req();
                  vin[i] = 1'b1;
               end
            end
            apply();
         end
      end
      vin = '0;
      apply();
      repeat (6) cycle();
   endtask

   task automatic test_flush();
      cur[1] = rnd_req();
      cur[1].trans_id = TRANS_ID_BITS'(6);
      vin = 3'b010;
      apply();
      cycle();
      cur[1].trans_id = TRANS_ID_BITS'(7);
      flush = 1'b1;
      apply();
      cycle();
      n_checks++;
      if (s_rdy !== '0) begin
         n_fail++; $display("FAIL flush_ready: got %b expected 000", s_rdy);
      end
      flush = 1'b0;
      vin   = '0;
      apply();
      for (int c = 0; c < 4; c++) begin
         cycle();
         n_checks++;
         if (s_wv !== 1'b0) begin
            n_fail++; $display("FAIL flush_leak[%0d]: got valid=%b tag=%0d expected valid=0", c, s_wv, s_out.trans_id);
         end
      end
   endtask

   task automatic test_reset_midflight();
      cur[0] = rnd_req();
      vin = 3'b001;
      apply();
      cycle();
      vin = '0;
      apply();
      repeat (LAT - 1) cycle();
      n_checks++;
      if (bus.wb_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL midflight_pre: got valid=%b expected 1", bus.wb_valid_o);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.wb_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL midflight_valid: got %b expected 0", bus.wb_valid_o);
      end
      n_checks++;
      if (bus.wb_trans_id_o !== '0 || bus.wb_data_o !== '0 || bus.wb_ex_o !== '0) begin
         n_fail++;
         $display("FAIL midflight_payload: got tag=%0d data=%0h expected tag=0 data=0", bus.wb_trans_id_o, bus.wb_data_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

`ifdef WB_ARB_SKID_EN
   task automatic test_skid_pair();
      do_reset();
      cur[0] = rnd_req();
      cur[0].trans_id = TRANS_ID_BITS'(3);
      cur[1] = rnd_req();
      cur[1].trans_id = TRANS_ID_BITS'(4);
      vin = 3'b011;
      apply();
      cycle();
      n_checks++;
      if (s_rdy[1:0] !== 2'b11) begin
         n_fail++; $display("FAIL skid_ready: got %b expected 11", s_rdy[1:0]);
      end
      vin = '0;
      apply();
      cycle();
      n_checks++;
      if (s_wv !== 1'b0) begin
         n_fail++; $display("FAIL skid_early: got valid=%b expected 0", s_wv);
      end
      cycle();
      n_checks++;
      if (s_wv !== 1'b1 || s_out.trans_id !== TRANS_ID_BITS'(3) || s_out.data !== cur[0].data) begin
         n_fail++; $display("FAIL skid_tag3: got valid=%b tag=%0d expected valid=1 tag=3", s_wv, s_out.trans_id);
      end
      cycle();
      n_checks++;
      if (s_wv !== 1'b1 || s_out.trans_id !== TRANS_ID_BITS'(4) || s_out.data !== cur[1].data) begin
         n_fail++; $display("FAIL skid_tag4: got valid=%b tag=%0d expected valid=1 tag=4", s_wv, s_out.trans_id);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_traffic();
      test_flush();
      test_reset_midflight();
`ifdef WB_ARB_SKID_EN
      test_skid_pair();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares one scoreboard write-back port between several multi-cycle functional units (FPU, PAU, multiplier) that finish out of order. Round-robin grant, one registered output stage driving one `trans_id_i`/`wbdata_i`/`ex_ex_i`/`wt_valid_i` lane of the issue stage. Losing requesters are back-pressured, or buffered when the skid option is compiled in. Flush-aware so that no squashed result reaches the scoreboard.

## Interface
- `NR_REQ`, default 3: number of requesters sharing the port; any value ≥ 2, not required to be a power of two.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `flush_i`  in  1: squash everything in flight inside the arbiter.
- `req_valid_i`  in  NR_REQ: requester i has a result.
- `req_ready_o`  out  NR_REQ: requester i's result is accepted this cycle.
- `req_trans_id_i`  in  NR_REQ×TRANS_ID_BITS: scoreboard tag per requester.
- `req_data_i`  in  NR_REQ×riscv::XLEN: result data per requester.
- `req_ex_i`  in  NR_REQ×exception_t: exception per requester.
- `wb_valid_o`  out  1: write-back lane valid.
- `wb_trans_id_o`  out  TRANS_ID_BITS: tag on the lane.
- `wb_data_o`  out  riscv::XLEN: data on the lane.
- `wb_ex_o`  out  exception_t: exception on the lane.

## Operation
- The scoreboard port never stalls. The output register is loaded every cycle, with either the granted payload or `wb_valid_o`=0.
- Candidate set without skid: `req_valid_i`. With skid: the skid-buffer valid bits.
- Pointer `rr_q`, range 0..NR_REQ-1:
  - Grant goes to the first candidate found searching `rr_q`, `rr_q+1`, … modulo NR_REQ.
  - After a grant to g: `rr_q` ← (g+1) mod NR_REQ.
  - With no grant, `rr_q` holds.
- Exactly one grant per cycle, at most. Grant is one-hot.
- Without skid:
  - `req_ready_o[i]` = grant[i], combinational from `req_valid_i`.
  - A requester holding valid with ready low must keep its payload stable.
- `flush_i`:
  - Output register cleared next edge: `wb_valid_o`=0.
  - Skid buffers cleared. `rr_q` unchanged. `req_ready_o` forced to 0 that cycle.
  - A requester handshake in the flush cycle is dropped.
- Exception payload passes through untouched. `wb_ex_o.valid` is meaningful only when `wb_valid_o`=1.

## Timing
- Reset values:
  - `wb_valid_o`=0, `wb_trans_id_o`=0, `wb_data_o`=0, `wb_ex_o`='0.
  - `rr_q`=0, skid valids=0.
  - `req_ready_o`=0 while reset is asserted.
- Latency without skid: a requester accepted at edge N appears on `wb_*_o` during cycle N+1, for exactly one cycle.
- Latency with skid: two cycles (skid capture, then output register).
- Throughput: one result per cycle, total.
- Starvation bound: a continuously valid requester is granted within NR_REQ cycles.
- Simultaneous events:
  - Flush plus valid requests: flush wins.
  - Skid entry granted while its requester presents a new result in the same cycle: the buffer refills in that cycle (ready=1).
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. An in-flight output is lost.

## Configuration
- `WB_ARB_SKID_EN` defined:
  - Per-requester 1-entry skid buffer (trans_id, data, ex).
  - `req_ready_o[i]` = !skid_valid[i] OR grant[i].
  - Fixed-latency units that cannot stall are safe while their issue rate is ≤ 1 per NR_REQ cycles.
- `WB_ARB_SKID_EN` undefined:
  - No buffers.
  - `req_ready_o` = grant. Arbitration is directly on the inputs.

## Structure
- `ariane_pkg` holds:
  - `wb_req_t` (trans_id, data, ex packed struct).
  - `WB_ARB_NR_REQ` default constant.
- Sub-module `wb_rr_pick`: a combinational one-hot round-robin selector over a candidate vector and pointer, returning grant and next pointer. The top level holds the skid registers, output register and `rr_q`.

## Test plan
- After reset, all three requesters valid with tags 1/2/3, held:
  - Outputs 1, 2, 3, 1, … on consecutive cycles starting one cycle after the first grant.
  - `rr_q` wraps 2→0.
- Only requester 2 valid, with tag 5 and data 0xDEAD:
  - `req_ready_o`=3'b100 that cycle.
  - Next cycle `wb_valid_o`=1, tag 5, data 0xDEAD.
- Requester 0 valid continuously, requester 1 pulses every cycle:
  - Neither waits more than 2 cycles.
  - No tag is duplicated or lost (checked against the scoreboard model).
- `flush_i` raised while requester 1 presents tag 7:
  - `req_ready_o`=0 that cycle.
  - No `wb_valid_o` for tag 7 after the flush, including from skid.
- `rst_i` asserted while `wb_valid_o`=1: `wb_valid_o` drops asynchronously and all outputs go to 0.
- With `WB_ARB_SKID_EN`, requesters 0 and 1 both fire one-cycle results (tags 3, 4) in the same cycle:
  - Both accepted (ready=2'b11).
  - Tag 3 appears two cycles later, tag 4 three cycles later.
